// File: rtl/shift_normalizer.sv
// shift_normalizer: multi-cycle left/right normalizer returning the normalized word and its shift count
module shift_normalizer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(WIDTH)-1:0] shift_amt,
  output logic                     zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d, zero_q, zero_d, hit;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = work_q;
  assign shift_amt = cnt_q;
  assign zero      = zero_q;
  assign hit       = zero_q || (mode_q ? work_q[0] : work_q[WIDTH-1]);
  // next state: accept in IDLE, shift one bit per cycle until the target bit is set, hold in DONE
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        work_d  = data_in;
        mode_d  = mode;
        cnt_d   = '0;
        zero_d  = (data_in == '0);
        state_d = SHIFT;
      end
      SHIFT: if (hit) state_d = DONE;
      else begin
        work_d = mode_q ? work_q >> 1 : work_q << 1;
        cnt_d  = cnt_q + CW'(1);
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and working registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed and random checks of normalized value, shift count, latency and handshake
module tb_shift_normalizer;
  logic       clk = 0, rst_n = 0, in_valid = 0, mode = 0, out_ready = 0;
  logic [7:0] data_in = 0;
  logic       in_ready, out_valid, zero;
  logic [7:0] data_out;
  logic [2:0] shift_amt;
  int passed = 0, total = 0;

  shift_normalizer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .shift_amt(shift_amt), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] d, input logic m, input logic [7:0] ed,
                       input logic [2:0] ea, input logic ez, input int el);
    int lat = 0;
    int g = 0;
    while (!in_ready && g < 20) begin
      tick;
      g++;
    end
    in_valid = 1; data_in = d; mode = m;
    tick;
    in_valid = 0; data_in = 8'($urandom); mode = ~m;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk("latency", lat, el);
    chk("data_out", data_out, ed);
    chk("shift_amt", shift_amt, ea);
    chk("zero", zero, ez);
  endtask

  task automatic consume;
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("out_valid_after_consume", out_valid, 0);
    chk("in_ready_after_consume", in_ready, 1);
  endtask

  initial begin
    logic [7:0] d, ed;
    logic m;
    int k, hold;
    tick; tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_shift_amt", shift_amt, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    tick;
    do_op(8'h13, 0, 8'h98, 3, 0, 4); consume;
    do_op(8'h28, 1, 8'h05, 3, 0, 4); consume;
    do_op(8'h00, 0, 8'h00, 0, 1, 1); consume;
    do_op(8'h00, 1, 8'h00, 0, 1, 1); consume;
    do_op(8'h01, 0, 8'h80, 7, 0, 8); consume;
    do_op(8'h80, 0, 8'h80, 0, 0, 1); consume;
    do_op(8'h80, 1, 8'h01, 7, 0, 8); consume;
    do_op(8'h13, 0, 8'h98, 3, 0, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); data_in = 8'h55; mode = 1;
      tick;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data_out", data_out, 8'h98);
      chk("bp_shift_amt", shift_amt, 3);
    end
    in_valid = 0;
    consume;
    do_op(8'h55, 0, 8'hAA, 1, 0, 2); consume;
    in_valid = 1; data_in = 8'h01; mode = 0;
    tick;
    in_valid = 0;
    tick; tick;
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_shift_amt", shift_amt, 0);
    tick; tick;
    rst_n = 1;
    tick;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    do_op(8'h40, 1, 8'h01, 6, 0, 7); consume;
    for (int n = 0; n < 25; n++) begin
      d = 8'($urandom);
      if (n % 7 == 0) d = 0;
      m = 1'($urandom);
      k = 0;
      if (d != 0) begin
        if (m) begin
          for (int b = 7; b >= 0; b--) if (d[b]) k = b;
        end else begin
          for (int b = 0; b < 8; b++) if (d[b]) k = 7 - b;
        end
      end
      ed = m ? d >> k : d << k;
      do_op(d, m, ed, 3'(k), d == 0, d == 0 ? 1 : k + 1);
      if (d != 0) chk("rnd_invariant", m ? (data_out << shift_amt) : (data_out >> shift_amt), d);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) tick;
      chk("rnd_hold", data_out, ed);
      consume;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
